// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle main controller:
//   - state_e      : controller state, 4-bit encoding exposed on state_o
//   - OP_*         : opcode class values of the op field
//   - SRC_B_*      : ALU B operand mux selects
//   - RES_*        : result mux selects
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_EXECR  = 4'd3,
        S_EXECI  = 4'd4,
        S_BRANCH = 4'd5,
        S_MEMRD  = 4'd6,
        S_MEMWR  = 4'd7,
        S_ALUWB  = 4'd8,
        S_MEMWB  = 4'd9,
        S_FAULT  = 4'd10
    } state_e;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/mc_wait_watchdog.sv
// ---------------------------------------------------------------------------
// mc_wait_watchdog
// Counts consecutive stalled memory cycles and flags the cycle in which the
// WAIT_TIMEOUT-th stalled cycle is happening, so the controller can enter
// its fault state on the following edge. WAIT_TIMEOUT = 0 removes the
// counter entirely and expire is tied low.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   stall      : memory access active and not completing this cycle
//   clear      : access completed or no access active; restart the count
//   expire     : this stalled cycle is the last one allowed
// ---------------------------------------------------------------------------
module mc_wait_watchdog #(
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic clear,
    output logic expire
);

    generate
        if (WAIT_TIMEOUT > 0) begin : g_wd
            localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_TIMEOUT - 1);

            logic [CNT_W-1:0] wait_cnt_q;
            logic [CNT_W-1:0] wait_cnt_d;

            always_comb begin
                wait_cnt_d = wait_cnt_q;
                if (clear) begin
                    wait_cnt_d = '0;
                end else if (stall) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end

            // NOTE: state registers use non-blocking assignment so every flop
            // samples the pre-edge value of the others in the same time step.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wait_cnt_q <= '0;
                end else begin
                    wait_cnt_q <= wait_cnt_d;
                end
            end

            // A ready in the same cycle removes the stall, so completion wins.
            assign expire = stall && (wait_cnt_q == LAST);
        end else begin : g_no_wd
            logic unused_inputs;
            assign unused_inputs = clk ^ reset ^ stall ^ clear;
            assign expire        = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mc_controller_hs.sv
// ---------------------------------------------------------------------------
// mc_controller_hs
// Main controller of a multicycle shared-bus datapath with a variable-latency
// memory handshake, conditional-execution squash, undefined-opcode trap and
// a stall watchdog that drops into a sticky FAULT state.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   op, funct, cond_ex  : decode fields (funct MSB = immediate, bit0 = load)
//   mem_ready           : memory completes the current access this cycle
//   mem_req, mem_w      : memory access active / write
//   adr_src             : address mux (0 PC, 1 ALU result)
//   alu_src_a/b, alu_op : ALU operand selects and funct decode enable
//   ir_write, next_pc   : instruction register load, PC update
//   reg_w, branch       : register file write, branch PC load
//   result_src          : result mux select
//   fault               : sticky fault flag
//   state_o             : current state encoding for debug
// ---------------------------------------------------------------------------
module mc_controller_hs
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 15,
    parameter int FUNCT_W      = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               cond_ex,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               adr_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               alu_op,
    output logic               ir_write,
    output logic               next_pc,
    output logic               mem_w,
    output logic               reg_w,
    output logic               branch,
    output logic [1:0]         result_src,
    output logic               fault,
    output logic [3:0]         state_o
);

    state_e state_q;
    state_e state_d;

    logic mem_access;
    logic stall;
    logic wait_clear;
    logic wait_expire;

    // Only the immediate flag and the load bit steer the sequence.
    logic unused_funct;
    assign unused_funct = ^funct[FUNCT_W-2:1];

    // mem_req is a pure function of state so the watchdog path into the
    // next-state logic stays free of combinational feedback.
    assign mem_access = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                        (state_q == S_MEMWR);
    assign mem_req    = mem_access;
    assign stall      = mem_access & ~mem_ready;
    assign wait_clear = mem_ready | ~mem_access;

    mc_wait_watchdog #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) u_wait_watchdog (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .clear (wait_clear),
        .expire(wait_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output and state_d gets a default before the case so no
    // path through the block leaves a signal unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        alu_op     = 1'b0;
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        branch     = 1'b0;
        result_src = RES_ALUOUT;
        fault      = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                // PC advances once, in the completing cycle only.
                ir_write   = mem_ready;
                next_pc    = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expire) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                if (!cond_ex) begin
                    state_d = S_FETCH;
                end else begin
                    case (op)
                        OP_MEM:  state_d = S_MEMADR;
                        OP_DP:   state_d = funct[FUNCT_W-1] ? S_EXECI : S_EXECR;
                        OP_BR:   state_d = S_BRANCH;
                        default: state_d = S_FAULT;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_b = SRC_B_IMM;
                state_d   = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_expire) begin
                    state_d = S_FAULT;
                end
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (wait_expire) begin
                    state_d = S_FAULT;
                end
            end
            S_EXECR: begin
                alu_op    = 1'b1;
                alu_src_b = SRC_B_REG;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_op    = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w      = 1'b1;
                result_src = RES_ALUOUT;
                state_d    = S_FETCH;
            end
            S_MEMWB: begin
                reg_w      = 1'b1;
                result_src = RES_RDATA;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                branch     = 1'b1;
                alu_src_b  = SRC_B_IMM;
                result_src = RES_ALU;
                state_d    = S_FETCH;
            end
            S_FAULT: begin
                fault   = 1'b1;
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    assign state_o = state_q;

endmodule
